// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   DW, DEPTH, AW     default geometry (32 x 32-bit)
//   LINK_REG_DEFAULT  JAL-class link destination
//   ZERO_REG          hardwired-zero register index
//   eff_waddr()       resolves a write port's effective destination
package regfile_pkg;

   localparam int unsigned DW               = 32;
   localparam int unsigned DEPTH            = 32;
   localparam int unsigned AW               = $clog2(DEPTH);
   localparam int unsigned LINK_REG_DEFAULT = 31;
   localparam int unsigned ZERO_REG         = 0;

   // The link target is an argument so parametrised instances can relocate it.
   function automatic int unsigned eff_waddr(input logic        link,
                                             input int unsigned addr,
                                             input int unsigned link_reg = LINK_REG_DEFAULT);
      return link ? link_reg : addr;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write (busy) bits.
//   clk, rst         clock, synchronous active-low reset
//   iss_en_i/addr_i  issue of a producer for a destination register
//   flush_i          clears every busy bit, overrides issue
//   wr_en_i          per-write-port enable
//   wr_addr_eff_i    per-write-port effective address, port w at [w*AW +: AW]
//   busy_o           DEPTH busy bits (bit 0 always 0)
module regfile_scoreboard
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = $clog2(DEPTH),
   parameter int unsigned NW    = 2
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                iss_en_i,
   input  logic [AW-1:0]       iss_addr_i,
   input  logic                flush_i,
   input  logic [NW-1:0]       wr_en_i,
   input  logic [NW*AW-1:0]    wr_addr_eff_i,
   output logic [DEPTH-1:0]    busy_o
);

   logic [DEPTH-1:0] busy_q, busy_d;

   // Applied lowest priority first so later assignments override:
   // write-clear, then issue-set, then flush.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned w = 0; w < NW; w++) begin
         if (wr_en_i[w])
            busy_d[wr_addr_eff_i[w*AW +: AW]] = 1'b0;
      end
      if (iss_en_i && (iss_addr_i != '0))
         busy_d[iss_addr_i] = 1'b1;
      if (flush_i)
         busy_d = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with link redirect and
// pending-write scoreboard.
//   clk, rst          clock, synchronous active-low reset
//   rd_addr/rd_data   NR combinational read ports
//   rd_busy           pending-producer flag per read port
//   wr_en/wr_link/wr_addr/wr_data  NW write ports, highest index wins
//   iss_en/iss_addr   producer issue (sets busy)
//   flush             clears all busy bits
// Optional: `define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
#(
   parameter int unsigned DW       = regfile_pkg::DW,
   parameter int unsigned DEPTH    = regfile_pkg::DEPTH,
   parameter int unsigned AW       = $clog2(DEPTH),
   parameter int unsigned NR       = 2,
   parameter int unsigned NW       = 2,
   parameter int unsigned LINK_REG = regfile_pkg::LINK_REG_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NR*AW-1:0]  rd_addr,
   output logic [NR*DW-1:0]  rd_data,
   output logic [NR-1:0]     rd_busy,
   input  logic [NW-1:0]     wr_en,
   input  logic [NW-1:0]     wr_link,
   input  logic [NW*AW-1:0]  wr_addr,
   input  logic [NW*DW-1:0]  wr_data,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic              flush
);

   import regfile_pkg::*;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [NW*AW-1:0] waddr_eff;
   logic [DEPTH-1:0] busy;

   always_comb begin
      waddr_eff = '0;
      for (int unsigned w = 0; w < NW; w++)
         waddr_eff[w*AW +: AW] = AW'(eff_waddr(wr_link[w], 32'(wr_addr[w*AW +: AW]), LINK_REG));
   end

   // Ascending port order: the last non-blocking write to an address wins,
   // giving the highest-indexed port priority on collisions.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         for (int unsigned w = 0; w < NW; w++) begin
            if (wr_en[w] && (waddr_eff[w*AW +: AW] != AW'(ZERO_REG)))
               mem_q[waddr_eff[w*AW +: AW]] <= wr_data[w*DW +: DW];
         end
      end
   end

   regfile_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .NW    (NW)
   ) u_sb (
      .clk           (clk),
      .rst           (rst),
      .iss_en_i      (iss_en),
      .iss_addr_i    (iss_addr),
      .flush_i       (flush),
      .wr_en_i       (wr_en),
      .wr_addr_eff_i (waddr_eff),
      .busy_o        (busy)
   );

   always_comb begin
      logic [AW-1:0] ra;
      logic [DW-1:0] data;
      logic          bsy;
`ifdef REGFILE_BYPASS_EN
      logic          hit;
`endif
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         ra   = rd_addr[k*AW +: AW];
         data = mem_q[ra];
         bsy  = busy[ra];
`ifdef REGFILE_BYPASS_EN
         hit = 1'b0;
         for (int unsigned w = 0; w < NW; w++) begin
            if (wr_en[w] && (waddr_eff[w*AW +: AW] != AW'(ZERO_REG)) &&
                (waddr_eff[w*AW +: AW] == ra)) begin
               hit  = 1'b1;
               data = wr_data[w*DW +: DW];
            end
         end
         // A forwarded write retires the producer unless a new one issues now.
         if (hit)
            bsy = iss_en && (iss_addr == ra);
`endif
         if (ra == AW'(ZERO_REG)) begin
            data = '0;
            bsy  = 1'b0;
         end
         rd_data[k*DW +: DW] = data;
         rd_busy[k]          = bsy;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int PAW = 6;
   localparam int PDW = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [2*AW-1:0] rd_addr;
   logic [2*DW-1:0] rd_data;
   logic [1:0]      rd_busy;
   logic [1:0]      wr_en, wr_link;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;
   logic            iss_en;
   logic [AW-1:0]   iss_addr;
   logic            flush;

   logic [4*PAW-1:0] pr_addr;
   logic [4*PDW-1:0] pr_data;
   logic [3:0]       pr_busy;
   logic [2:0]       pw_en, pw_link;
   logic [3*PAW-1:0] pw_addr;
   logic [3*PDW-1:0] pw_data;
   logic             p_iss_en;
   logic [PAW-1:0]   p_iss_addr;
   logic             p_flush;

   int errors = 0;
   int checks = 0;

   regfile_mp dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_link(wr_link), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
   );

   regfile_mp #(.DW(64), .DEPTH(64), .NR(4), .NW(3)) dut_p (
      .clk(clk), .rst(rst), .rd_addr(pr_addr), .rd_data(pr_data), .rd_busy(pr_busy),
      .wr_en(pw_en), .wr_link(pw_link), .wr_addr(pw_addr), .wr_data(pw_data),
      .iss_en(p_iss_en), .iss_addr(p_iss_addr), .flush(p_flush)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      wr_en = '0; wr_link = '0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
      pw_en = '0; pw_link = '0; pw_addr = '0; pw_data = '0;
      p_iss_en = 1'b0; p_iss_addr = '0; p_flush = 1'b0;
   endtask

   task automatic write1(input int port, input logic [4:0] a, input logic [31:0] d);
      wr_en[port]            = 1'b1;
      wr_addr[port*AW +: AW] = a;
      wr_data[port*DW +: DW] = d;
   endtask

   task automatic test_reset();
      clear_inputs();
      rd_addr = '0;
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      rd_addr = {5'd6, 5'd5};
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
         errors++; $display("FAIL reset_init: data=%h busy=%b expected 0/00", rd_data, rd_busy);
      end
      write1(0, 5'd5, 32'h1234);
      tick();
      clear_inputs();
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h1234) begin
         errors++; $display("FAIL pre_reset_r5: got %h expected 00001234", rd_data[31:0]);
      end
      // Writes and issue during reset must be ignored.
      rst = 1'b0;
      write1(1, 5'd6, 32'h66);
      iss_en = 1'b1; iss_addr = 5'd6;
      tick(); tick();
      rst = 1'b1;
      clear_inputs();
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h0) begin
         errors++; $display("FAIL reset_r5: got %h expected 0", rd_data[31:0]);
      end
      checks++;
      if (rd_data[63:32] !== 32'h0 || rd_busy !== 2'b00) begin
         errors++; $display("FAIL reset_r6: data=%h busy=%b expected 0/00", rd_data[63:32], rd_busy);
      end
   endtask

   task automatic test_write_read();
      write1(0, 5'd3, 32'hDEADBEEF);
      tick();
      clear_inputs();
      rd_addr = {5'd0, 5'd3};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wr_rd_r3: got %h expected deadbeef", rd_data[31:0]);
      end
      write1(1, 5'd0, 32'hFFFFFFFF);
      tick();
      clear_inputs();
      #1;
      checks++;
      if (rd_data[63:32] !== 32'h0) begin
         errors++; $display("FAIL r0_zero: got %h expected 0", rd_data[63:32]);
      end
      // Distinct addresses on both ports commit together.
      write1(0, 5'd1, 32'hA);
      write1(1, 5'd2, 32'hB);
      tick();
      clear_inputs();
      rd_addr = {5'd2, 5'd1};
      #1;
      checks++;
      if (rd_data !== {32'hB, 32'hA}) begin
         errors++; $display("FAIL dual_write: got %h expected 0000000b0000000a", rd_data);
      end
   endtask

   task automatic test_collision_link();
      write1(0, 5'd7, 32'h11);
      write1(1, 5'd7, 32'h22);
      tick();
      clear_inputs();
      rd_addr = {5'd0, 5'd7};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h22) begin
         errors++; $display("FAIL collision_r7: got %h expected 00000022", rd_data[31:0]);
      end
      write1(0, 5'd4, 32'h44);
      tick();
      clear_inputs();
      write1(1, 5'd4, 32'h400);
      wr_link[1] = 1'b1;
      tick();
      clear_inputs();
      rd_addr = {5'd4, 5'd31};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h400) begin
         errors++; $display("FAIL link_r31: got %h expected 00000400", rd_data[31:0]);
      end
      checks++;
      if (rd_data[63:32] !== 32'h44) begin
         errors++; $display("FAIL link_r4_kept: got %h expected 00000044", rd_data[63:32]);
      end
      // wr_link without wr_en must not write r31.
      wr_link[0] = 1'b1; wr_data[31:0] = 32'hBAD;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h400) begin
         errors++; $display("FAIL link_no_en: got %h expected 00000400", rd_data[31:0]);
      end
   endtask

   task automatic test_scoreboard();
      iss_en = 1'b1; iss_addr = 5'd9;
      tick();
      clear_inputs();
      rd_addr = {5'd0, 5'd9};
      #1;
      checks++;
      if (rd_busy !== 2'b01) begin
         errors++; $display("FAIL iss_busy: got %b expected 01", rd_busy);
      end
      write1(1, 5'd9, 32'h90);
      tick();
      clear_inputs();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h90) begin
         errors++; $display("FAIL wb_clear: busy=%b data=%h expected 0/00000090", rd_busy[0], rd_data[31:0]);
      end
      iss_en = 1'b1; iss_addr = 5'd9;
      write1(0, 5'd9, 32'h99);
      tick();
      clear_inputs();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h99) begin
         errors++; $display("FAIL iss_over_wb: busy=%b data=%h expected 1/00000099", rd_busy[0], rd_data[31:0]);
      end
      flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd10;
      tick();
      clear_inputs();
      rd_addr = {5'd10, 5'd9};
      #1;
      checks++;
      if (rd_busy !== 2'b00) begin
         errors++; $display("FAIL flush: got %b expected 00", rd_busy);
      end
      iss_en = 1'b1; iss_addr = 5'd0;
      tick();
      clear_inputs();
      rd_addr = {5'd0, 5'd0};
      #1;
      checks++;
      if (rd_busy !== 2'b00) begin
         errors++; $display("FAIL iss_r0: got %b expected 00", rd_busy);
      end
      // Link writeback must clear busy on r31, not on the raw address.
      iss_en = 1'b1; iss_addr = 5'd31;
      tick();
      clear_inputs();
      iss_en = 1'b1; iss_addr = 5'd8;
      tick();
      clear_inputs();
      write1(0, 5'd8, 32'h31);
      wr_link[0] = 1'b1;
      tick();
      clear_inputs();
      rd_addr = {5'd8, 5'd31};
      #1;
      checks++;
      if (rd_busy !== 2'b10 || rd_data[31:0] !== 32'h31) begin
         errors++; $display("FAIL link_busy: busy=%b data=%h expected 10/00000031", rd_busy, rd_data[31:0]);
      end
   endtask

   task automatic test_bypass();
      write1(0, 5'd12, 32'h1);
      tick();
      clear_inputs();
      iss_en = 1'b1; iss_addr = 5'd12;
      tick();
      clear_inputs();
      write1(0, 5'd12, 32'hCAFE);
      rd_addr = {5'd12, 5'd0};
      #1;
`ifdef REGFILE_BYPASS_EN
      checks++;
      if (rd_data[63:32] !== 32'hCAFE || rd_busy[1] !== 1'b0) begin
         errors++; $display("FAIL bypass_fwd: data=%h busy=%b expected 0000cafe/0", rd_data[63:32], rd_busy[1]);
      end
`else
      checks++;
      if (rd_data[63:32] !== 32'h1 || rd_busy[1] !== 1'b1) begin
         errors++; $display("FAIL bypass_stale: data=%h busy=%b expected 00000001/1", rd_data[63:32], rd_busy[1]);
      end
`endif
      tick();
      clear_inputs();
      #1;
      checks++;
      if (rd_data[63:32] !== 32'hCAFE || rd_busy[1] !== 1'b0) begin
         errors++; $display("FAIL bypass_commit: data=%h busy=%b expected 0000cafe/0", rd_data[63:32], rd_busy[1]);
      end
   endtask

   task automatic test_parametric();
      pw_en = 3'b101;
      pw_addr[0*PAW +: PAW] = 6'd63;
      pw_data[0*PDW +: PDW] = 64'hFFFF_0000_FFFF_0000;
      pw_addr[2*PAW +: PAW] = 6'd63;
      pw_data[2*PDW +: PDW] = 64'h0123_4567_89AB_CDEF;
      tick();
      clear_inputs();
      pr_addr = {4{6'd63}};
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (pr_data[k*PDW +: PDW] !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL param_r63_port%0d: got %h expected 0123456789abcdef", k, pr_data[k*PDW +: PDW]);
         end
      end
   endtask

   initial begin
      clear_inputs();
      rd_addr = '0;
      pr_addr = '0;
      test_reset();
      test_write_read();
      test_collision_link();
      test_scoreboard();
      test_bypass();
      test_parametric();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the pipelined MIPS core. It is the next generation of the single-write, two-read file.
- Adds configurable width, depth, read-port and write-port counts.
- Per-port link redirect for JAL-class writebacks.
- Pending-write scoreboard (busy bits) that the ID stage uses for load-use and multi-cycle hazard stalls.
- Reads are combinational in ID; writes and scoreboard updates happen at posedge clk from WB and issue.

Parameters:
DW, 32, data width of each register
DEPTH, 32, number of registers (power of 2, >=2)
AW, $clog2(DEPTH), register address width (derived)
NR, 2, number of read ports
NW, 2, number of write ports (port NW-1 has highest priority)
LINK_REG, 31, target register when wr_link is set

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-low reset (0 at posedge = reset)
rd_addr  in  NR*AW  read addresses, port k at [k*AW +: AW]
rd_data  out  NR*DW  read data, port k at [k*DW +: DW]
rd_busy  out  NR  1 = addressed register has a pending producer
wr_en  in  NW  write enable per write port
wr_link  in  NW  1 = redirect this port's write to LINK_REG
wr_addr  in  NW*AW  write addresses
wr_data  in  NW*DW  write data
iss_en  in  1  issue of an instruction that will write iss_addr
iss_addr  in  AW  destination of the issued instruction
flush  in  1  clear all busy bits (pipeline squash)

Behaviour:
- Reset: the reset is synchronous and active-low (rst==0 sampled at posedge clk). It clears all DEPTH registers to 0 and all busy bits to 0. Writes, issue and flush are ignored in that cycle. Reset mid-operation discards any in-flight write.
- After reset, rd_data = 0 and rd_busy = 0 for every port.
- Effective write address per port is LINK_REG if wr_link, else wr_addr. wr_link is honoured only when wr_en=1.
- Register 0 is hardwired to 0:
  - writes to effective address 0 are discarded;
  - reads of address 0 return 0;
  - busy[0] is never set.
- Write collision: if several enabled ports target the same effective address in one cycle, the highest-indexed port wins. Writes to distinct addresses all commit in the same cycle.
- Read latency is 0: rd_data is combinational from rd_addr and array state.
- Scoreboard, per register, evaluated at posedge when not in reset. Priority, highest first:
  1. flush=1: all busy bits cleared; iss_en is ignored that cycle.
  2. iss_en=1 and iss_addr!=0: busy[iss_addr] set. This wins over a same-cycle write to that address, because the new producer supersedes the old one.
  3. Any enabled write to effective address A clears busy[A].
- rd_busy[k] = busy[rd_addr k], subject to bypass masking (see Optional Feature). rd_busy is always 0 for address 0.
- The block applies no stall itself; the hazard unit consumes rd_busy.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: write-to-read forwarding in the same cycle.
  - If an enabled write targets a nonzero effective address equal to rd_addr k, rd_data k returns the winning port's wr_data that cycle, not the stored value.
  - rd_busy[k] reads 0 unless iss_en targets the same address that cycle.
- Undefined: rd_data returns the stored (pre-write) value, and rd_busy is the raw busy bit. Same-cycle WB-to-ID reads see stale data, and the pipeline must stall one cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DW, DEPTH, AW, LINK_REG_DEFAULT (31), ZERO_REG (0);
  - function eff_waddr(link, addr) returning the effective write address.
- One natural sub-module: regfile_scoreboard. It holds the DEPTH busy bits plus the flush/issue/write priority logic and exposes busy vector lookup.
- The array and bypass muxing stay in the top module.

Test Plan:
- Reset: drive rst=0 for 2 cycles after writing r5=0x1234 -> r5 reads 0, all rd_busy=0.
- Write/read: port0 writes r3=0xDEADBEEF, next cycle rd_addr0=3 -> 0xDEADBEEF. Write r0=0xFFFF_FFFF -> r0 reads 0.
- Collision and link:
  - port0 and port1 both write r7 (0x11, 0x22) -> r7=0x22.
  - wr_link=1, wr_addr=4, data 0x400 -> r31=0x400, r4 unchanged.
- Scoreboard:
  - iss_en r9 -> rd_busy=1 next cycle. Write r9 -> busy clears.
  - Same-cycle iss r9 and write r9 -> busy stays 1, data committed.
  - flush with iss_en r10 -> all busy 0.
- Bypass: write r12=0xCAFE while rd_addr1=12 in the same cycle:
  - with REGFILE_BYPASS_EN: rd_data1=0xCAFE, rd_busy1=0;
  - without: old value returned.
- Parametric: NR=4, NW=3, DEPTH=64, DW=64. Write r63 with a 64-bit pattern on port2 -> readable on all 4 read ports.
